fft4_stream: RTL

- Streaming successor of the team's combinational 4-point FFT.
- Accepts complex signed samples serially over a valid/ready interface and buffers one 4-sample frame.
- Computes the 4-point DFT (forward or inverse, selected per frame) in a 2-stage registered butterfly.
- Emits the 4 complex bins serially, in natural order, over a valid/ready interface. Sits between the sample source and downstream spectral processing.

---
 rtl/fft4_stream_pkg.sv | 21 ++
 rtl/fft4_bfly.sv | 38 +++
 rtl/fft4_stream.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fft4_stream_pkg.sv
// Shared types and constants for the streaming 4-point FFT.
package fft4_stream_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC1 = 2'd1,
        CALC2 = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int FRAME_LEN = 4;

    // Nominal component width of a complex sample (matches the default W).
    localparam int CPLX_W = 8;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft4_bfly.sv
// Combinational radix-2 complex butterfly: a+b' and a-b', where b' is b or -j*b.
module fft4_bfly #(
    parameter int IW = 8
) (
    input  logic signed [IW-1:0] i_a_re,
    input  logic signed [IW-1:0] i_a_im,
    input  logic signed [IW-1:0] i_b_re,
    input  logic signed [IW-1:0] i_b_im,
    input  logic                 i_rot,
    output logic signed [IW:0]   o_sum_re,
    output logic signed [IW:0]   o_sum_im,
    output logic signed [IW:0]   o_dif_re,
    output logic signed [IW:0]   o_dif_im
);

    logic signed [IW:0] w_a_re, w_a_im, w_b_re, w_b_im;

    assign w_a_re = {i_a_re[IW-1], i_a_re};
    assign w_a_im = {i_a_im[IW-1], i_a_im};
    assign w_b_re = {i_b_re[IW-1], i_b_re};
    assign w_b_im = {i_b_im[IW-1], i_b_im};

    // -j*b = (b_im, -b_re); folding the negation into the add keeps IW+1 bits exact.
    always_comb begin
        if (i_rot) begin
            o_sum_re = w_a_re + w_b_im;
            o_sum_im = w_a_im - w_b_re;
            o_dif_re = w_a_re - w_b_im;
            o_dif_im = w_a_im + w_b_re;
        end else begin
            o_sum_re = w_a_re + w_b_re;
            o_sum_im = w_a_im + w_b_im;
            o_dif_re = w_a_re - w_b_re;
            o_dif_im = w_a_im - w_b_im;
        end
    end

endmodule

// File: rtl/fft4_stream.sv
// Streaming 4-point FFT: serial load, 2-stage registered butterfly, serial output.
// Optional 1/4 result scaling is enabled by defining FFT4_STREAM_SCALE_EN.
module fft4_stream
    import fft4_stream_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W+1:0] out_re,
    output logic signed [W+1:0] out_im,
    output logic [1:0]          out_idx,
    output logic                out_last
);

    state_t r_state, w_state_next;
    logic [1:0] r_load_cnt, r_out_cnt;
    logic       r_inv;

    logic signed [W-1:0] r_smp_re [FRAME_LEN];
    logic signed [W-1:0] r_smp_im [FRAME_LEN];

    logic signed [W:0] w_s_re [2], w_s_im [2], w_d_re [2], w_d_im [2];
    logic signed [W:0] r_s_re [2], r_s_im [2], r_d_re [2], r_d_im [2];

    logic signed [W+1:0] w_x_re [FRAME_LEN], w_x_im [FRAME_LEN];
    logic signed [W+1:0] w_bin_re [FRAME_LEN], w_bin_im [FRAME_LEN];
    logic signed [W+1:0] r_bin_re [FRAME_LEN], r_bin_im [FRAME_LEN];

    logic w_in_fire, w_out_fire;

    assign in_ready   = (r_state == LOAD);
    assign out_valid  = (r_state == OUT);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    assign out_re   = out_valid ? r_bin_re[r_out_cnt] : '0;
    assign out_im   = out_valid ? r_bin_im[r_out_cnt] : '0;
    assign out_idx  = out_valid ? r_out_cnt : 2'd0;
    assign out_last = out_valid && (r_out_cnt == 2'(FRAME_LEN-1));

    // Stage 1: (a,c) -> s0/d0 and (b,d) -> s1/d1.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stage1
            fft4_bfly #(.IW(W)) u_bfly (
                .i_a_re   (r_smp_re[gi]),
                .i_a_im   (r_smp_im[gi]),
                .i_b_re   (r_smp_re[gi+2]),
                .i_b_im   (r_smp_im[gi+2]),
                .i_rot    (1'b0),
                .o_sum_re (w_s_re[gi]),
                .o_sum_im (w_s_im[gi]),
                .o_dif_re (w_d_re[gi]),
                .o_dif_im (w_d_im[gi])
            );
        end
    endgenerate

    fft4_bfly #(.IW(W+1)) u_bfly_even (
        .i_a_re   (r_s_re[0]),
        .i_a_im   (r_s_im[0]),
        .i_b_re   (r_s_re[1]),
        .i_b_im   (r_s_im[1]),
        .i_rot    (1'b0),
        .o_sum_re (w_x_re[0]),
        .o_sum_im (w_x_im[0]),
        .o_dif_re (w_x_re[2]),
        .o_dif_im (w_x_im[2])
    );

    fft4_bfly #(.IW(W+1)) u_bfly_odd (
        .i_a_re   (r_d_re[0]),
        .i_a_im   (r_d_im[0]),
        .i_b_re   (r_d_re[1]),
        .i_b_im   (r_d_im[1]),
        .i_rot    (1'b1),
        .o_sum_re (w_x_re[1]),
        .o_sum_im (w_x_im[1]),
        .o_dif_re (w_x_re[3]),
        .o_dif_im (w_x_im[3])
    );

    // Inverse transform exchanges bins 1 and 3; even bins are unaffected.
    generate
        for (gi = 0; gi < FRAME_LEN; gi++) begin : g_bin
            localparam int ALT = (gi % 2 == 1) ? (FRAME_LEN - gi) : gi;
            logic signed [W+1:0] w_sel_re, w_sel_im;
            assign w_sel_re = r_inv ? w_x_re[ALT] : w_x_re[gi];
            assign w_sel_im = r_inv ? w_x_im[ALT] : w_x_im[gi];
`ifdef FFT4_STREAM_SCALE_EN
            assign w_bin_re[gi] = w_sel_re >>> 2;
            assign w_bin_im[gi] = w_sel_im >>> 2;
`else
            assign w_bin_re[gi] = w_sel_re;
            assign w_bin_im[gi] = w_sel_im;
`endif
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD:  if (w_in_fire && r_load_cnt == 2'(FRAME_LEN-1)) w_state_next = CALC1;
            CALC1: w_state_next = CALC2;
            CALC2: w_state_next = OUT;
            OUT:   if (w_out_fire && r_out_cnt == 2'(FRAME_LEN-1)) w_state_next = LOAD;
            default: w_state_next = LOAD;
        endcase
    end

    // Counters wrap to 0 naturally after the 4th transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= LOAD;
            r_load_cnt <= 2'd0;
            r_out_cnt  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (w_in_fire)  r_load_cnt <= r_load_cnt + 2'd1;
            if (w_out_fire) r_out_cnt  <= r_out_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_smp_re[r_load_cnt] <= in_re;
            r_smp_im[r_load_cnt] <= in_im;
            if (r_load_cnt == 2'd0) r_inv <= in_inv;
        end
        if (r_state == CALC1) begin
            r_s_re <= w_s_re;
            r_s_im <= w_s_im;
            r_d_re <= w_d_re;
            r_d_im <= w_d_im;
        end
        if (r_state == CALC2) begin
            r_bin_re <= w_bin_re;
            r_bin_im <= w_bin_im;
        end
    end

endmodule
